verificador_contador16b: RTL and testbench
==========================================

VERIFICADOR_CONTADOR16B -- requirements
Module: verificador_contador16b

Interface
REQ-001 Parameter: ERR_W, 8, width of the error counter.
REQ-002 Ports: CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Ports: RESET_L  input  1  reset, asynchronous, active-low.
REQ-004 Ports: ENB  input  1  counter enable, as driven to the observed counter.
REQ-005 Ports: MODO  input  2  counter mode, as driven to the observed counter.
REQ-006 Ports: D  input  16  parallel-load data, as driven to the observed counter.
REQ-007 Ports: Q  input  16  observed counter value.
REQ-008 Ports: RCO  input  1  observed ripple-carry-out.
REQ-009 Ports: Paridad  input  1  observed parity bit.
REQ-010 Ports: SYNC  output  1  model aligned with the counter; checks active.
REQ-011 Ports: ERR  output  1  one-cycle pulse per cycle with any mismatch.
REQ-012 Ports: ERR_Q, ERR_RCO, ERR_PAR  output  1 each  sticky per-field mismatch flags.
REQ-013 Ports: ERR_CNT  output  ERR_W  count of ERR pulses.
REQ-014 Ports: EXP_Q  output  16  model's expected Q.

Function
REQ-015 Counter semantics, applied at each rising edge with ENB=1:
- MODO=00: Q+1.
- MODO=01: Q-1.
- MODO=10: Q-3.
- MODO=11: load D.
REQ-016 With ENB=0, Q holds and RCO=0.
REQ-017 RCO=1 for exactly the cycle after a wrap; RCO=0 after every load and every non-wrapping step.
- MODO=00 wrap: FFFF->0000.
- MODO=01 wrap: 0000->FFFF.
- MODO=10 wrap: old Q<3, i.e. 0000->FFFD, 0001->FFFE, 0002->FFFF.
REQ-018 Paridad shall equal the XOR reduction of the current Q.
REQ-019 At each rising edge, EXP_Q and the expected RCO are updated from the ENB, MODO and D sampled at that edge.
REQ-020 FSM states: UNSYNC, SYNC, RESYNC; reset state is UNSYNC.
REQ-021 UNSYNC: no compares; on an edge with ENB=1 and MODO=11, load EXP_Q=D and go to SYNC.
REQ-022 SYNC: Q, RCO and Paridad are compared combinationally against the model after each edge; the registered result appears on ERR one cycle later (latency 1).
REQ-023 SYNC with a Q mismatch: go to RESYNC; the model is reloaded as next(observed Q, sampled ENB/MODO/D).
REQ-024 RESYNC: compares are suppressed for one cycle, then return to SYNC.
REQ-025 RCO or Paridad mismatch alone (Q matches) shall not leave SYNC.
REQ-026 A load (ENB=1, MODO=11) in any state forces EXP_Q=D and next state SYNC; this overrides RESYNC.
REQ-027 ERR_CNT increments by 1 per ERR pulse and saturates at 2^ERR_W-1 with no wrap.
REQ-028 Sticky flags stay set until reset; SYNC=1 only in state SYNC.

Reset
REQ-029 RESET_L=0 asynchronously forces:
- state UNSYNC;
- EXP_Q=0000, expected RCO=0;
- SYNC=0, ERR=0, ERR_Q=0, ERR_RCO=0, ERR_PAR=0, ERR_CNT=0.
REQ-030 Reset asserted mid-operation discards any pending ERR pulse.
REQ-031 After release, checking resumes only after a load.

Structure
REQ-032 A shared package holds:
- MODO encodings: MODO_SUBE=00, MODO_BAJA1=01, MODO_BAJA3=10, MODO_CARGA=11;
- FSM state encodings;
- width constant 16.
REQ-033 One combinational sub-module, modelo_siguiente, computes next Q and next RCO from (Q, ENB, MODO, D); it is shared by the SYNC and RESYNC paths.

Verification
REQ-034 Load 0x1234 then 5 cycles MODO=00 with a correct counter -> SYNC=1, EXP_Q=0x1239, ERR never pulses, ERR_CNT=0.
REQ-035 Load 0xFFFE, MODO=00 -> Q=FFFF then 0000 with RCO=1 on the 0000 cycle only; MODO=10 from 0001 -> FFFE with RCO=1; no ERR.
REQ-036 Inject Q=0x0050 when 0x0042 is expected -> ERR pulses one cycle later, ERR_Q=1, ERR_CNT=1, state RESYNC then SYNC, following checks pass against 0x0050-based values.
REQ-037 Force Paridad inverted for 3 cycles -> 3 ERR pulses, ERR_PAR=1, ERR_CNT=3, SYNC stays 1.
REQ-038 ERR_W=2 with 5 forced mismatches -> ERR_CNT saturates at 3.
REQ-039 Assert RESET_L=0 mid-count, in the cycle after a mismatch -> all outputs 0 immediately, no ERR pulse, UNSYNC until the next load.

Source files
------------

// File: rtl/verificador_contador16b_pkg.sv
// Shared definitions for the 16-bit counter checker: mode encodings,
// checker FSM states and the observed counter width.
package verificador_contador16b_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    MODO_SUBE  = 2'b00,
    MODO_BAJA1 = 2'b01,
    MODO_BAJA3 = 2'b10,
    MODO_CARGA = 2'b11
  } modo_t;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'b00,
    ST_SYNC   = 2'b01,
    ST_RESYNC = 2'b10
  } estado_t;

endpackage

// File: rtl/verificador_contador16b_modelo_siguiente.sv
// Golden next-state function of the observed counter: next Q and next RCO
// from the current value and the control inputs sampled at the edge.
module modelo_siguiente
  import verificador_contador16b_pkg::*;
(
  input  logic [CNT_W-1:0] q,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q_next,
  output logic             rco_next
);

  always_comb begin
    q_next   = q;
    rco_next = 1'b0;
    if (enb) begin
      case (modo_t'(modo))
        MODO_SUBE: begin
          q_next   = q + CNT_W'(1);
          rco_next = (q == '1);
        end
        MODO_BAJA1: begin
          q_next   = q - CNT_W'(1);
          rco_next = (q == '0);
        end
        MODO_BAJA3: begin
          q_next   = q - CNT_W'(3);
          rco_next = (q < CNT_W'(3));
        end
        MODO_CARGA: begin
          q_next   = d;
          rco_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/verificador_contador16b.sv
// Online checker for a 16-bit up/down/load counter: tracks the counter with
// a reference model and flags Q, RCO and parity mismatches once aligned.
module verificador_contador16b
  import verificador_contador16b_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [CNT_W-1:0] D,
  input  logic [CNT_W-1:0] Q,
  input  logic             RCO,
  input  logic             Paridad,
  output logic             SYNC,
  output logic             ERR,
  output logic             ERR_Q,
  output logic             ERR_RCO,
  output logic             ERR_PAR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] EXP_Q
);

  estado_t          state, state_next;
  logic [CNT_W-1:0] exp_q, exp_q_next, model_base, model_q;
  logic             exp_rco, exp_rco_next, model_rco;
  logic             carga, compara, mis_q, mis_rco, mis_par, mis_any;

  assign carga   = ENB && (modo_t'(MODO) == MODO_CARGA);
  assign compara = (state == ST_SYNC);
  assign mis_q   = compara && (Q != exp_q);
  assign mis_rco = compara && (RCO != exp_rco);
  assign mis_par = compara && (Paridad != ^Q);
  assign mis_any = mis_q || mis_rco || mis_par;

  // On a Q mismatch the model re-seeds from the observed value instead.
  assign model_base = mis_q ? Q : exp_q;

  modelo_siguiente u_modelo (
    .q       (model_base),
    .enb     (ENB),
    .modo    (MODO),
    .d       (D),
    .q_next  (model_q),
    .rco_next(model_rco)
  );

  always_comb begin
    state_next   = state;
    exp_q_next   = model_q;
    exp_rco_next = model_rco;
    case (state)
      ST_UNSYNC: begin
        if (!carga) begin
          exp_q_next   = exp_q;
          exp_rco_next = 1'b0;
        end
      end
      ST_SYNC: begin
        if (mis_q) state_next = ST_RESYNC;
      end
      ST_RESYNC: state_next = ST_SYNC;
      default:   state_next = ST_UNSYNC;
    endcase
    if (carga) state_next = ST_SYNC;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state   <= ST_UNSYNC;
      exp_q   <= '0;
      exp_rco <= 1'b0;
      ERR     <= 1'b0;
      ERR_Q   <= 1'b0;
      ERR_RCO <= 1'b0;
      ERR_PAR <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state   <= state_next;
      exp_q   <= exp_q_next;
      exp_rco <= exp_rco_next;
      ERR     <= mis_any;
      ERR_Q   <= ERR_Q | mis_q;
      ERR_RCO <= ERR_RCO | mis_rco;
      ERR_PAR <= ERR_PAR | mis_par;
      if (mis_any && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + ERR_W'(1);
    end
  end

  assign SYNC  = (state == ST_SYNC);
  assign EXP_Q = exp_q;

endmodule

// File: tb/tb_verificador_contador16b.sv
// Scoreboard bench: the bench plays the observed counter (with planted faults)
// and predicts checker outputs from an arithmetic model of the counter rules.
module tb_verificador_contador16b;
  import verificador_contador16b_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        ENB;
  logic [1:0]  MODO;
  logic [15:0] D, Q;
  logic        RCO, Paridad;

  logic        sync_a, err_a, errq_a, errrco_a, errpar_a;
  logic [7:0]  cnt_a;
  logic [15:0] expq_a;
  logic        sync_b, err_b, errq_b, errrco_b, errpar_b;
  logic [1:0]  cnt_b;
  logic [15:0] expq_b;

  verificador_contador16b #(.ERR_W(8)) dut_a (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q),
    .RCO(RCO), .Paridad(Paridad), .SYNC(sync_a), .ERR(err_a), .ERR_Q(errq_a),
    .ERR_RCO(errrco_a), .ERR_PAR(errpar_a), .ERR_CNT(cnt_a), .EXP_Q(expq_a)
  );

  verificador_contador16b #(.ERR_W(2)) dut_b (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q),
    .RCO(RCO), .Paridad(Paridad), .SYNC(sync_b), .ERR(err_b), .ERR_Q(errq_b),
    .ERR_RCO(errrco_b), .ERR_PAR(errpar_b), .ERR_CNT(cnt_b), .EXP_Q(expq_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          sync;
    bit          err;
    bit          eq;
    bit          er;
    bit          ep;
    int          cnt;
    int          cnt2;
    logic [15:0] exp_q;
  } expect_t;

  expect_t     sb[$];
  int          total = 0;
  int          bad = 0;

  logic [15:0] cnt_q;
  bit          cnt_rco;
  logic [15:0] m_exp;
  bit          m_rco, m_synced, m_resync, m_err, m_eq, m_er, m_ep;
  int          m_cnt;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Counter rule as plain integer arithmetic; a wrap is leaving 0..65535.
  task automatic ref_next(input logic [15:0] q, input bit e, input logic [1:0] m,
                          input logic [15:0] d, output logic [15:0] nq, output bit nrco);
    int v;
    if (!e) begin
      nq = q; nrco = 1'b0;
    end else if (m == 2'b11) begin
      nq = d; nrco = 1'b0;
    end else begin
      v    = int'(q) + ((m == 2'b00) ? 1 : (m == 2'b01) ? -1 : -3);
      nrco = (v < 0) || (v > 65535);
      nq   = 16'((v + 65536) % 65536);
    end
  endtask

  task automatic model_reset();
    m_exp = '0; m_rco = 1'b0; m_synced = 1'b0; m_resync = 1'b0;
    m_err = 1'b0; m_eq = 1'b0; m_er = 1'b0; m_ep = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [15:0] sq, input bit srco, input bit spar,
                            input bit e, input logic [1:0] m, input logic [15:0] d);
    bit          load, bq, br, bp, nr;
    logic [15:0] nq;
    load = e && (m == 2'b11);
    bq = 1'b0; br = 1'b0; bp = 1'b0;
    if (m_synced) begin
      bq = (sq != m_exp);
      br = (srco != m_rco);
      bp = (spar != ^sq);
    end
    m_err = bq | br | bp;
    if (m_err) m_cnt++;
    m_eq |= bq; m_er |= br; m_ep |= bp;
    if (!m_synced && !m_resync && !load) begin
      m_rco = 1'b0;
    end else begin
      ref_next(bq ? sq : m_exp, e, m, d, nq, nr);
      m_exp = nq; m_rco = nr;
    end
    if (load || m_resync) begin
      m_synced = 1'b1; m_resync = 1'b0;
    end else if (bq) begin
      m_synced = 1'b0; m_resync = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input bit e, input logic [1:0] m, input logic [15:0] d,
                                input bit inj_q, input logic [15:0] q_val,
                                input bit inj_par, input bit inj_rco);
    logic [15:0] sq, nq;
    bit          sr, sp, nr;
    expect_t     ex;
    ENB = e; MODO = m; D = d;
    sq = Q; sr = RCO; sp = Paridad;
    @(posedge CLK);
    #1;
    model_edge(sq, sr, sp, e, m, d);
    ref_next(cnt_q, e, m, d, nq, nr);
    cnt_q = inj_q ? q_val : nq;
    cnt_rco = nr;
    Q = cnt_q;
    RCO = cnt_rco ^ inj_rco;
    Paridad = (^cnt_q) ^ inj_par;
    ex.sync  = m_synced;
    ex.err   = m_err;
    ex.eq    = m_eq;
    ex.er    = m_er;
    ex.ep    = m_ep;
    ex.cnt   = (m_cnt > 255) ? 255 : m_cnt;
    ex.cnt2  = (m_cnt > 3) ? 3 : m_cnt;
    ex.exp_q = m_exp;
    sb.push_back(ex);
  endtask

  task automatic step(input bit e, input logic [1:0] m, input logic [15:0] d);
    apply_stimulus(e, m, d, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    #1;
    RESET_L = 1'b0;
    ENB = 1'b0;
    #1;
    check_output("rst_sync", sync_a, 0);
    check_output("rst_err", err_a, 0);
    check_output("rst_flags", {errq_a, errrco_a, errpar_a}, 0);
    check_output("rst_cnt", cnt_a, 0);
    check_output("rst_cnt_w2", cnt_b, 0);
    check_output("rst_expq", expq_a, 0);
    @(posedge CLK);
    #1;
    check_output("rst_err_held", err_a, 0);
    RESET_L = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    expect_t ex;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        check_output("sync", sync_a, ex.sync);
        check_output("err", err_a, ex.err);
        check_output("err_q", errq_a, ex.eq);
        check_output("err_rco", errrco_a, ex.er);
        check_output("err_par", errpar_a, ex.ep);
        check_output("err_cnt", cnt_a, ex.cnt);
        check_output("exp_q", expq_a, ex.exp_q);
        check_output("sync_w2", sync_b, ex.sync);
        check_output("err_cnt_w2", cnt_b, ex.cnt2);
      end
    end
  end

  initial begin : stimulus
    bit          e, iq, ip, ir;
    logic [1:0]  m;
    logic [15:0] d, qv;
    logic [15:0] edge_vals [5];
    edge_vals = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFE, 16'hFFFF};
    RESET_L = 1'b0; ENB = 1'b0; MODO = 2'b00; D = '0;
    Q = '0; RCO = 1'b0; Paridad = 1'b0; cnt_q = '0; cnt_rco = 1'b0;
    model_reset();
    reset_dut();

    // Idle without a load: checker must stay unaligned even with garbage Q.
    apply_stimulus(1'b1, 2'b00, 16'h0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    step(1'b1, 2'b01, 16'h0);

    step(1'b1, 2'b11, 16'h1234);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 16'h0);
    step(1'b0, 2'b00, 16'h0);
    check_output("load_count_expq", expq_a, 16'h1239);
    check_output("load_count_sync", sync_a, 1);
    check_output("load_count_cnt", cnt_a, 0);

    step(1'b1, 2'b11, 16'hFFFE);
    step(1'b1, 2'b00, 16'h0);
    step(1'b1, 2'b00, 16'h0);
    check_output("wrap_up_q", expq_a, 16'h0000);
    step(1'b1, 2'b11, 16'h0001);
    step(1'b1, 2'b10, 16'h0);
    check_output("wrap_dn3_q", expq_a, 16'hFFFE);
    step(1'b1, 2'b01, 16'h0);
    step(1'b0, 2'b00, 16'h0);
    check_output("wrap_cnt", cnt_a, 0);

    step(1'b1, 2'b11, 16'h0040);
    step(1'b1, 2'b00, 16'h0);
    apply_stimulus(1'b1, 2'b00, 16'h0, 1'b1, 16'h0050, 1'b0, 1'b0);
    step(1'b1, 2'b00, 16'h0);
    check_output("inj_err", err_a, 1);
    check_output("inj_errq", errq_a, 1);
    check_output("inj_cnt", cnt_a, 1);
    check_output("inj_resync", sync_a, 0);
    step(1'b1, 2'b00, 16'h0);
    check_output("inj_resync_back", sync_a, 1);
    check_output("inj_reseed_q", expq_a, 16'h0052);
    step(1'b1, 2'b00, 16'h0);

    reset_dut();
    step(1'b1, 2'b11, 16'h7000);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 2'b01, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 16'h0);
    check_output("par_cnt", cnt_a, 3);
    check_output("par_flag", errpar_a, 1);
    check_output("par_sync", sync_a, 1);

    reset_dut();
    step(1'b1, 2'b11, 16'h0003);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 2'b10, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 2'b00, 16'h0);
    check_output("sat_cnt_w8", cnt_a, 5);
    check_output("sat_cnt_w2", cnt_b, 3);

    reset_dut();
    step(1'b1, 2'b11, 16'h0100);
    step(1'b1, 2'b00, 16'h0);
    apply_stimulus(1'b1, 2'b00, 16'h0, 1'b1, 16'h0777, 1'b0, 1'b0);
    reset_dut();
    apply_stimulus(1'b1, 2'b00, 16'h0, 1'b1, 16'h1111, 1'b0, 1'b1);
    step(1'b1, 2'b01, 16'h0);
    check_output("post_rst_unsync", sync_a, 0);
    step(1'b1, 2'b11, 16'hFFFF);

    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 99) < 80);
      m = 2'($urandom_range(0, 3));
      if (m == 2'b11 && $urandom_range(0, 3) != 0) m = 2'b00;
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = edge_vals[$urandom_range(0, 4)];
      iq = ($urandom_range(0, 99) < 4);
      qv = 16'($urandom);
      ip = ($urandom_range(0, 99) < 4);
      ir = ($urandom_range(0, 99) < 3);
      apply_stimulus(e, m, d, iq, qv, ip, ir);
    end
    step(1'b0, 2'b00, 16'h0);
    step(1'b0, 2'b00, 16'h0);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain actual=%0d required=0 pending entries", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
